// File: rtl/pim_cmd_scheduler.sv
`timescale 1ns/1ps
// pim_cmd_scheduler
//   Host-side command scheduler for the PIM matrix-multiply memory. Matmul
//   commands (src1, src2, dst) are queued in a FIFO. They are issued to the
//   memory one at a time: the addresses are driven, start is pulsed once, and
//   the scheduler waits for mem_done before it issues the next command.
//   Completed commands are counted. A command that does not complete within
//   TIMEOUT_CYC cycles raises a sticky error flag.
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   cmd_valid/ready     host command handshake (ready = FIFO not full)
//   cmd_src1/src2/dst   host command addresses
//   src1/src2/dst_addr  addresses of the issued command, held until the next issue
//   start               one-cycle issue pulse to the memory
//   mem_done            completion pulse from the memory; ignored outside WAIT
//   busy                FIFO non-empty or a command is in progress
//   cmd_count           completed-command counter, wraps at 2^16
//   err_timeout         sticky timeout flag
//   clear_err           synchronous clear of err_timeout
module pim_cmd_scheduler #(
    parameter int unsigned LEN         = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [LEN-1:0] cmd_src1,
    input  logic [LEN-1:0] cmd_src2,
    input  logic [LEN-1:0] cmd_dst,
    output logic [LEN-1:0] src1_addr,
    output logic [LEN-1:0] src2_addr,
    output logic [LEN-1:0] dst_addr,
    output logic           start,
    input  logic           mem_done,
    output logic           busy,
    output logic [15:0]    cmd_count,
    output logic           err_timeout,
    input  logic           clear_err
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [AW:0]   OCC_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   OCC_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state, state_next;

    logic [LEN-1:0] fifo_src1 [DEPTH];
    logic [LEN-1:0] fifo_src2 [DEPTH];
    logic [LEN-1:0] fifo_dst  [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    occ, occ_next;
    logic [CW-1:0]  wait_cnt;
    logic           push, pop, done_hit, timeout_hit;

    assign push        = cmd_valid && cmd_ready;
    assign pop         = (state == ISSUE);
    assign done_hit    = (state == WAIT) && mem_done;
    // mem_done takes priority over a timeout on the same cycle
    assign timeout_hit = (state == WAIT) && !mem_done && (wait_cnt == WAIT_LAST);
    assign busy        = (occ != '0) || (state != IDLE);

    always_comb begin
        occ_next = occ;
        case ({push, pop})
            2'b10:   occ_next = occ + OCC_ONE;
            2'b01:   occ_next = occ - OCC_ONE;
            default: occ_next = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_src1[wr_ptr] <= cmd_src1;
            fifo_src2[wr_ptr] <= cmd_src2;
            fifo_dst[wr_ptr]  <= cmd_dst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            cmd_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            occ       <= occ_next;
            // registered from next occupancy, so it always reflects the
            // occupancy currently held and a same-cycle pop cannot raise it
            cmd_ready <= (occ_next != OCC_FULL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (occ != '0) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (done_hit || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start       <= 1'b0;
            src1_addr   <= '0;
            src2_addr   <= '0;
            dst_addr    <= '0;
            wait_cnt    <= '0;
            cmd_count   <= '0;
            err_timeout <= 1'b0;
        end else begin
            start <= pop;
            if (pop) begin
                src1_addr <= fifo_src1[rd_ptr];
                src2_addr <= fifo_src2[rd_ptr];
                dst_addr  <= fifo_dst[rd_ptr];
                wait_cnt  <= '0;
            end else if (state == WAIT && !done_hit && !timeout_hit) begin
                wait_cnt <= wait_cnt + CNT_ONE;
            end
            if (done_hit) cmd_count <= cmd_count + 16'd1;
            // a new timeout wins over clear_err in the same cycle
            if (timeout_hit)    err_timeout <= 1'b1;
            else if (clear_err) err_timeout <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pim_cmd_scheduler.sv
`timescale 1ns/1ps
module tb_pim_cmd_scheduler;
    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_src1 = '0, cmd_src2 = '0, cmd_dst = '0;
    logic [31:0] src1_addr, src2_addr, dst_addr;
    logic        start;
    logic        mem_done = 1'b0;
    logic        busy;
    logic [15:0] cmd_count;
    logic        err_timeout;
    logic        clear_err = 1'b0;

    pim_cmd_scheduler #(.LEN(32), .DEPTH(4), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
        .src1_addr(src1_addr), .src2_addr(src2_addr), .dst_addr(dst_addr),
        .start(start), .mem_done(mem_done), .busy(busy), .cmd_count(cmd_count),
        .err_timeout(err_timeout), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s1, s2, d;
        int unsigned lat;       // WAIT edge carrying mem_done; 0 = never
        bit          clr_at_to; // clear_err on the timeout edge
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t        vecs [6];
    logic [95:0] exp_q [$];
    logic [95:0] mon_exp;
    int unsigned checks = 0, failures = 0;
    int unsigned starts = 0, exp_starts = 0;
    logic [15:0] exp_count = '0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every start must carry the oldest accepted command
    always @(negedge clk) begin
        if (start === 1'b1) begin
            starts++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL start_unexpected: got start=1 expected no start");
            end else begin
                mon_exp = exp_q.pop_front();
                check("start_addrs", {src1_addr, src2_addr, dst_addr}, mon_exp);
            end
        end
    end

    task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        int unsigned n = 0;
        cmd_src1 = a; cmd_src2 = b; cmd_dst = c; cmd_valid = 1'b1;
        while (!cmd_ready && n < 60) begin
            @(posedge clk); #1; n++;
        end
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL push_wait: got cmd_ready=0 expected 1 within 60 cycles");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back({a, b, c});
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_start();
        bit ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (start) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL start_wait: got no start expected start within 40 cycles");
        end
    endtask

    task automatic pulse_done();
        mem_done = 1'b1;
        @(posedge clk); #1;
        mem_done = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'd100,        32'd200,        32'd300,        10, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{32'h0000_0001,  32'h0000_0002,  32'h0000_0003,  1,  1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'hDEAD_BEEF,  32'hCAFE_F00D,  32'h1234_5678,  0,  1'b0, 1'b0, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF,  32'h8000_0000,  32'h0000_0000,  20, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{32'h0A0A_0A0A,  32'h5050_5050,  32'hA5A5_A5A5,  16, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{32'h1111_1111,  32'h2222_2222,  32'h3333_3333,  15, 1'b0, 1'b1, 1'b0};

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_start", 96'(start), 96'(0));
        check("rst_busy", 96'(busy), 96'(0));
        check("rst_count", 96'(cmd_count), 96'(0));
        check("rst_ready", 96'(cmd_ready), 96'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", 96'(cmd_ready), 96'(1));

        // Table: one command per row, with latency, hold, done and timeout checks
        for (int unsigned r = 0; r < 6; r++) begin
            int unsigned last;
            push_cmd(vecs[r].s1, vecs[r].s2, vecs[r].d);
            @(posedge clk); #1;
            check("lat_k1", 96'(start), 96'(0));
            @(posedge clk); #1;
            check("lat_k2", 96'(start), 96'(1));
            exp_starts++;
            last = (vecs[r].lat == 0) ? TMO : vecs[r].lat;
            for (int unsigned c = 1; c <= last; c++) begin
                mem_done  = (c == vecs[r].lat);
                clear_err = (c == TMO) && vecs[r].clr_at_to;
                @(posedge clk); #1;
                mem_done  = 1'b0;
                clear_err = 1'b0;
                check("start_in_wait", 96'(start), 96'(0));
                check("addr_hold", {src1_addr, src2_addr, dst_addr},
                      {vecs[r].s1, vecs[r].s2, vecs[r].d});
                if (c == TMO - 1) check("err_early", 96'(err_timeout), 96'(0));
            end
            if (vecs[r].exp_done) exp_count++;
            check("row_count", 96'(cmd_count), 96'(exp_count));
            check("row_err", 96'(err_timeout), 96'(vecs[r].exp_err));
            check("row_busy", 96'(busy), 96'(0));
            if (vecs[r].exp_err) begin
                clear_err = 1'b1;
                @(posedge clk); #1;
                clear_err = 1'b0;
                check("clear_err", 96'(err_timeout), 96'(0));
            end
        end

        // FIFO full: A in flight with memory stalled, B..E fill the FIFO,
        // F is only accepted once B has been popped
        push_cmd(32'hA0, 32'hA1, 32'hA2);
        wait_start();
        exp_starts++;
        push_cmd(32'hB0, 32'hB1, 32'hB2);
        push_cmd(32'hC0, 32'hC1, 32'hC2);
        push_cmd(32'hD0, 32'hD1, 32'hD2);
        push_cmd(32'hE0, 32'hE1, 32'hE2);
        check("ready_full", 96'(cmd_ready), 96'(0));
        check("busy_full", 96'(busy), 96'(1));
        fork
            push_cmd(32'hF0, 32'hF1, 32'hF2);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk); #1;
                    check("ready_stall", 96'(cmd_ready), 96'(0));
                end
                pulse_done();
                exp_count++;
                check("count_a", 96'(cmd_count), 96'(exp_count));
                check("b2b_j0_ready", 96'(cmd_ready), 96'(0));
                @(posedge clk); #1;
                check("b2b_j1_start", 96'(start), 96'(0));
                check("b2b_j1_ready", 96'(cmd_ready), 96'(0));
                @(posedge clk); #1;
                check("b2b_j2_start", 96'(start), 96'(1));
                check("b2b_j2_ready", 96'(cmd_ready), 96'(1));
            end
        join
        for (int i = 0; i < 5; i++) begin
            if (i > 0) wait_start();
            exp_starts++;
            @(posedge clk); #1;
            pulse_done();
            exp_count++;
        end
        check("fill_count", 96'(cmd_count), 96'(exp_count));
        check("fill_busy", 96'(busy), 96'(0));
        check("fill_queue", 96'(exp_q.size()), 96'(0));

        // Async reset mid-WAIT with two commands queued
        push_cmd(32'h70, 32'h71, 32'h72);
        wait_start();
        exp_starts++;
        push_cmd(32'h80, 32'h81, 32'h82);
        push_cmd(32'h90, 32'h91, 32'h92);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("arst_start", 96'(start), 96'(0));
        check("arst_busy", 96'(busy), 96'(0));
        check("arst_count", 96'(cmd_count), 96'(0));
        check("arst_addrs", {src1_addr, src2_addr, dst_addr}, 96'(0));
        check("arst_ready", 96'(cmd_ready), 96'(0));
        exp_q.delete();
        exp_count = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("arst_ready_rel", 96'(cmd_ready), 96'(1));
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("arst_no_start", 96'(start), 96'(0));
            check("arst_idle", 96'(busy), 96'(0));
        end

        check("start_total", 96'(starts), 96'(exp_starts));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
